// File: rtl/ws2812_chain_driver.sv
// ws2812_chain_driver
// Serial driver for a chain of WS2812B LEDs. Takes 24-bit GRB pixels on a
// valid/ready stream and holds up to one of them in a buffer. Each pixel is
// scaled by a global brightness when it loads into the shifter, then sent on
// the one-wire NRZ line MSB first. A frame is LED_COUNT pixels followed by a
// TRESET-cycle low latch.
//
// Ports:
//   clk, rst_n   - clock; asynchronous active-low reset
//   s_valid      - pixel valid
//   s_ready      - pixel buffer empty
//   s_data       - pixel, [23:16]=G, [15:8]=R, [7:0]=B
//   brightness   - global scale, sampled when a pixel loads into the shifter
//   dout         - LED data line
//   busy         - a frame is in progress (any state other than idle)
//   frame_done   - one-cycle pulse when a complete frame finishes its latch
//   underrun     - one-cycle pulse when a frame is aborted for lack of data
module ws2812_chain_driver #(
  parameter int LED_COUNT = 12,
  parameter int TBIT      = 15,
  parameter int T0H       = 5,
  parameter int T1H       = 10,
  parameter int TRESET    = 1200
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [23:0] s_data,
  input  logic [7:0]  brightness,
  output logic        dout,
  output logic        busy,
  output logic        frame_done,
  output logic        underrun
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] HIGH  = 2'd1;
  localparam logic [1:0] LOW   = 2'd2;
  localparam logic [1:0] LATCH = 2'd3;

  // One timer serves both bit phases and the latch, so it is sized for the longer.
  localparam int TMAX = (TRESET > TBIT) ? TRESET : TBIT;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int PW   = (LED_COUNT > 1) ? $clog2(LED_COUNT) : 1;

  localparam logic [TW-1:0] HI1_LAST   = TW'(T1H - 1);
  localparam logic [TW-1:0] HI0_LAST   = TW'(T0H - 1);
  localparam logic [TW-1:0] LO1_LAST   = TW'(TBIT - T1H - 1);
  localparam logic [TW-1:0] LO0_LAST   = TW'(TBIT - T0H - 1);
  localparam logic [TW-1:0] LATCH_LAST = TW'(TRESET - 1);
  localparam logic [PW-1:0] PIX_LAST   = PW'(LED_COUNT - 1);

  logic [1:0]    state_q, state_d;
  logic [23:0]   buf_q, buf_d;
  logic          buf_full_q, buf_full_d;
  logic [23:0]   shift_q, shift_d;
  logic [4:0]    bit_q, bit_d;
  logic [PW-1:0] pix_q, pix_d;
  logic [TW-1:0] tim_q, tim_d;
  logic          abort_q, abort_d;
  logic          dout_q, dout_d;
  logic          frame_done_q, frame_done_d;
  logic          underrun_q, underrun_d;

  // Each channel becomes (c * (brightness + 1)) >> 8, so 255 is identity and 0 blanks.
  function automatic logic [23:0] scale_pixel(input logic [23:0] px, input logic [7:0] br);
    logic [15:0] mult;
    logic [15:0] pg;
    logic [15:0] pr;
    logic [15:0] pb;
    mult = {8'd0, br} + 16'd1;
    pg   = {8'd0, px[23:16]} * mult;
    pr   = {8'd0, px[15:8]} * mult;
    pb   = {8'd0, px[7:0]} * mult;
    return {pg[15:8], pr[15:8], pb[15:8]};
  endfunction

  // Next-state logic. The buffer accepts only while empty and the shifter
  // loads only while it is full, so the two never compete for buf_d.
  always_comb begin
    state_d      = state_q;
    buf_d        = buf_q;
    buf_full_d   = buf_full_q;
    shift_d      = shift_q;
    bit_d        = bit_q;
    pix_d        = pix_q;
    tim_d        = tim_q;
    abort_d      = abort_q;
    frame_done_d = 1'b0;
    underrun_d   = 1'b0;

    if (s_valid && !buf_full_q) begin
      buf_d      = s_data;
      buf_full_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (buf_full_q) begin
          shift_d    = scale_pixel(buf_q, brightness);
          buf_full_d = 1'b0;
          pix_d      = '0;
          bit_d      = 5'd0;
          tim_d      = '0;
          abort_d    = 1'b0;
          state_d    = HIGH;
        end
      end
      HIGH: begin
        if (tim_q == (shift_q[23] ? HI1_LAST : HI0_LAST)) begin
          tim_d   = '0;
          state_d = LOW;
        end else begin
          tim_d = tim_q + TW'(1);
        end
      end
      LOW: begin
        if (tim_q == (shift_q[23] ? LO1_LAST : LO0_LAST)) begin
          tim_d = '0;
          if (bit_q != 5'd23) begin
            bit_d   = bit_q + 5'd1;
            shift_d = {shift_q[22:0], 1'b0};
            state_d = HIGH;
          end else if (pix_q == PIX_LAST) begin
            state_d = LATCH;
          end else if (buf_full_q) begin
            // Next pixel goes straight out with no idle cycle between pixels.
            shift_d    = scale_pixel(buf_q, brightness);
            buf_full_d = 1'b0;
            pix_d      = pix_q + PW'(1);
            bit_d      = 5'd0;
            state_d    = HIGH;
          end else begin
            // Source fell behind: abandon the frame and latch what was sent.
            underrun_d = 1'b1;
            abort_d    = 1'b1;
            state_d    = LATCH;
          end
        end else begin
          tim_d = tim_q + TW'(1);
        end
      end
      default: begin
        if (tim_q == LATCH_LAST) begin
          tim_d        = '0;
          state_d      = IDLE;
          frame_done_d = !abort_q;
        end else begin
          tim_d = tim_q + TW'(1);
        end
      end
    endcase

    // The line is registered from the next state so it changes on the edge that enters HIGH.
    dout_d = (state_d == HIGH);
  end

  // State registers; reset drops the line and discards any buffered pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      buf_q        <= '0;
      buf_full_q   <= 1'b0;
      shift_q      <= '0;
      bit_q        <= 5'd0;
      pix_q        <= '0;
      tim_q        <= '0;
      abort_q      <= 1'b0;
      dout_q       <= 1'b0;
      frame_done_q <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      buf_q        <= buf_d;
      buf_full_q   <= buf_full_d;
      shift_q      <= shift_d;
      bit_q        <= bit_d;
      pix_q        <= pix_d;
      tim_q        <= tim_d;
      abort_q      <= abort_d;
      dout_q       <= dout_d;
      frame_done_q <= frame_done_d;
      underrun_q   <= underrun_d;
    end
  end

  assign s_ready    = !buf_full_q;
  assign busy       = (state_q != IDLE);
  assign dout       = dout_q;
  assign frame_done = frame_done_q;
  assign underrun   = underrun_q;

endmodule
